bp_fe_pred_update_arb: RTL and testbench

Arbitrates predictor training traffic into the single shared BTB/BHT write path of the frontend PC generator. Two requesters compete. Redirect-driven training (mispredict / non-branch clear) from the backend command path has priority. Attaboy training (correct-prediction reinforcement) is buffered in a small FIFO and protected from starvation. The winner is placed in a one-entry output register, which is held until the predictor write port accepts it with `upd_yumi_i`.

---
 rtl/bp_fe_pkg.sv | 30 +++
 rtl/bp_fe_pred_update_fifo.sv | 64 ++++++
 rtl/bp_fe_pred_update_arb.sv | 112 +++++++++++
 tb/tb_bp_fe_pred_update_arb.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/bp_fe_pkg.sv
// Frontend shared types: predictor-update payload struct (width-parameterised via macro)
// and the encoding of which training source produced an update.
`ifndef BP_FE_PKG_SV
`define BP_FE_PKG_SV

`define BP_FE_DECLARE_PRED_UPDATE_S(vaddr_width_mp, meta_width_mp) \
  typedef struct packed { \
    logic [vaddr_width_mp-1:0] pc; \
    logic [meta_width_mp-1:0]  meta; \
    logic                      taken; \
    logic                      ntaken; \
    logic                      nonbr; \
    bp_fe_upd_src_e            src; \
  } bp_fe_pred_update_s

package bp_fe_pkg;

  typedef enum logic {
    e_upd_src_attaboy  = 1'b0,
    e_upd_src_redirect = 1'b1
  } bp_fe_upd_src_e;

  localparam int vaddr_width_gp = 39;
  localparam int meta_width_gp  = 64;

  `BP_FE_DECLARE_PRED_UPDATE_S(vaddr_width_gp, meta_width_gp);

endpackage

`endif

// File: rtl/bp_fe_pred_update_fifo.sv
// Attaboy buffer: valid/ready in, valid/yumi out, flush clears it at the next edge.
// Head is visible one cycle after enqueue; ready reflects occupancy only, not a same-cycle dequeue.
module bp_fe_pred_update_fifo
  import bp_fe_pkg::*;
 #(parameter int width_p = 8,
   parameter int els_p   = 4,
   localparam int ptr_width_lp = $clog2(els_p),
   localparam int cnt_width_lp = $clog2(els_p + 1))
  (input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic                    flush_i,
   input  logic                    v_i,
   input  logic [width_p-1:0]      data_i,
   output logic                    ready_o,
   output logic                    v_o,
   output logic [width_p-1:0]      data_o,
   input  logic                    yumi_i,
   output logic [cnt_width_lp-1:0] count_o);

  logic [width_p-1:0]      mem_q [els_p];
  logic [ptr_width_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [cnt_width_lp-1:0] count_q, count_d;
  logic                    enq, deq;

  assign ready_o = (count_q < cnt_width_lp'(els_p));
  assign v_o     = (count_q != '0);
  assign data_o  = mem_q[rptr_q];
  assign count_o = count_q;
  assign enq     = v_i & ready_o & ~flush_i;
  assign deq     = yumi_i & v_o & ~flush_i;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (enq) wptr_d = wptr_q + ptr_width_lp'(1);
      if (deq) rptr_d = rptr_q + ptr_width_lp'(1);
      count_d = count_q + cnt_width_lp'(enq) - cnt_width_lp'(deq);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/bp_fe_pred_update_arb.sv
// Arbitrates redirect and attaboy training into one registered predictor update.
// Redirects win unless attaboys have starved; the output holds until upd_yumi_i.
module bp_fe_pred_update_arb
  import bp_fe_pkg::*;
 #(parameter int vaddr_width_p  = 39,
   parameter int meta_width_p   = 64,
   parameter int fifo_els_p     = 4,
   parameter int starve_limit_p = 8,
   localparam int occ_width_lp    = $clog2(fifo_els_p + 1),
   localparam int starve_width_lp = $clog2(starve_limit_p + 1))
  (input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic                     redir_v_i,
   input  logic [vaddr_width_p-1:0] redir_pc_i,
   input  logic [meta_width_p-1:0]  redir_meta_i,
   input  logic                     redir_taken_i,
   input  logic                     redir_ntaken_i,
   input  logic                     redir_nonbr_i,
   output logic                     redir_yumi_o,
   input  logic                     ab_v_i,
   input  logic [vaddr_width_p-1:0] ab_pc_i,
   input  logic [meta_width_p-1:0]  ab_meta_i,
   input  logic                     ab_taken_i,
   input  logic                     ab_ntaken_i,
   output logic                     ab_ready_o,
   input  logic                     flush_i,
   output logic                     upd_v_o,
   output logic [vaddr_width_p-1:0] upd_pc_o,
   output logic [meta_width_p-1:0]  upd_meta_o,
   output logic                     upd_taken_o,
   output logic                     upd_ntaken_o,
   output logic                     upd_nonbr_o,
   output logic                     upd_src_o,
   input  logic                     upd_yumi_i,
   output logic [occ_width_lp-1:0]  occupancy_o);

  `BP_FE_DECLARE_PRED_UPDATE_S(vaddr_width_p, meta_width_p);

  bp_fe_pred_update_s         ab_in, ab_head, redir_upd, upd_q, upd_d;
  logic                       upd_v_q, upd_v_d;
  logic [starve_width_lp-1:0] starve_q, starve_d;
  logic                       ab_head_v, ab_avail, starve_sat, load_ok;
  logic                       force_ab, grant_redir, grant_ab;

  assign ab_in     = '{pc: ab_pc_i, meta: ab_meta_i, taken: ab_taken_i, ntaken: ab_ntaken_i,
                       nonbr: 1'b0, src: e_upd_src_attaboy};
  assign redir_upd = '{pc: redir_pc_i, meta: redir_meta_i, taken: redir_taken_i,
                       ntaken: redir_ntaken_i, nonbr: redir_nonbr_i, src: e_upd_src_redirect};

  bp_fe_pred_update_fifo #(
    .width_p($bits(bp_fe_pred_update_s)),
    .els_p  (fifo_els_p)
  ) ab_fifo (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .flush_i  (flush_i),
    .v_i      (ab_v_i),
    .data_i   (ab_in),
    .ready_o  (ab_ready_o),
    .v_o      (ab_head_v),
    .data_o   (ab_head),
    .yumi_i   (grant_ab),
    .count_o  (occupancy_o)
  );

  // A flushing FIFO cannot be dequeued, so its head is not offered to the arbiter.
  assign ab_avail    = ab_head_v & ~flush_i;
  assign starve_sat  = (starve_q == starve_width_lp'(starve_limit_p));
  assign load_ok     = ~upd_v_q | upd_yumi_i;
  assign force_ab    = starve_sat & ab_avail;
  assign grant_redir = load_ok & redir_v_i & ~force_ab;
  assign grant_ab    = load_ok & ab_avail & (force_ab | ~redir_v_i);

  assign redir_yumi_o = grant_redir;

  always_comb begin
    starve_d = starve_q;
    if (flush_i || !ab_head_v || grant_ab) starve_d = '0;
    else if (grant_redir && !starve_sat)   starve_d = starve_q + starve_width_lp'(1);
  end

  always_comb begin
    upd_v_d = upd_v_q;
    upd_d   = upd_q;
    if (load_ok) begin
      upd_v_d = grant_redir | grant_ab;
      if (grant_redir)   upd_d = redir_upd;
      else if (grant_ab) upd_d = ab_head;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      upd_v_q  <= 1'b0;
      upd_q    <= '0;
      starve_q <= '0;
    end else begin
      upd_v_q  <= upd_v_d;
      upd_q    <= upd_d;
      starve_q <= starve_d;
    end
  end

  assign upd_v_o      = upd_v_q;
  assign upd_pc_o     = upd_q.pc;
  assign upd_meta_o   = upd_q.meta;
  assign upd_taken_o  = upd_q.taken;
  assign upd_ntaken_o = upd_q.ntaken;
  assign upd_nonbr_o  = upd_q.nonbr;
  assign upd_src_o    = upd_q.src;

endmodule

// File: tb/tb_bp_fe_pred_update_arb.sv
// Scoreboard bench: a queue-based policy model predicts every loaded update; a monitor
// compares each accepted DUT update against the head of the expected queue.
module tb_bp_fe_pred_update_arb;
  localparam int VW  = 39;
  localparam int MW  = 64;
  localparam int ELS = 4;
  localparam int LIM = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          redir_v, redir_taken, redir_ntaken, redir_nonbr, redir_yumi;
  logic [VW-1:0] redir_pc, ab_pc, upd_pc;
  logic [MW-1:0] redir_meta, ab_meta, upd_meta;
  logic          ab_v, ab_taken, ab_ntaken, ab_ready, flush;
  logic          upd_v, upd_taken, upd_ntaken, upd_nonbr, upd_src, upd_yumi;
  logic [2:0]    occupancy;

  bp_fe_pred_update_arb #(.vaddr_width_p(VW), .meta_width_p(MW),
                          .fifo_els_p(ELS), .starve_limit_p(LIM)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .redir_v_i(redir_v), .redir_pc_i(redir_pc), .redir_meta_i(redir_meta),
    .redir_taken_i(redir_taken), .redir_ntaken_i(redir_ntaken), .redir_nonbr_i(redir_nonbr),
    .redir_yumi_o(redir_yumi),
    .ab_v_i(ab_v), .ab_pc_i(ab_pc), .ab_meta_i(ab_meta),
    .ab_taken_i(ab_taken), .ab_ntaken_i(ab_ntaken), .ab_ready_o(ab_ready),
    .flush_i(flush),
    .upd_v_o(upd_v), .upd_pc_o(upd_pc), .upd_meta_o(upd_meta),
    .upd_taken_o(upd_taken), .upd_ntaken_o(upd_ntaken), .upd_nonbr_o(upd_nonbr),
    .upd_src_o(upd_src), .upd_yumi_i(upd_yumi), .occupancy_o(occupancy));

  typedef struct {
    logic [VW-1:0] pc;
    logic [MW-1:0] meta;
    logic          t, nt, nb, src;
  } upd_t;

  upd_t mq[$];   // model of buffered attaboys
  upd_t sb[$];   // expected updates in load order
  bit   m_v;
  int   m_starve;
  int   tests, fails;
  logic [VW-1:0] hold_pc;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    redir_v = 0; redir_pc = '0; redir_meta = '0;
    redir_taken = 0; redir_ntaken = 0; redir_nonbr = 0;
    ab_v = 0; ab_pc = '0; ab_meta = '0; ab_taken = 0; ab_ntaken = 0;
    flush = 0; upd_yumi = 0;
  endtask

  task automatic cycle(bit rv, bit av, bit fl, bit yr);
    upd_t r, a;
    bit   ready, load_ok, ab_av, force_ab, gr, ga, enq;
    @(negedge clk);
    r.pc = VW'({$urandom, $urandom}); r.meta = {$urandom, $urandom};
    r.t = 1'($urandom); r.nt = 1'($urandom); r.nb = 1'($urandom); r.src = 1'b1;
    a.pc = VW'({$urandom, $urandom}); a.meta = {$urandom, $urandom};
    a.t = 1'($urandom); a.nt = 1'($urandom); a.nb = 1'b0; a.src = 1'b0;
    redir_v = rv; redir_pc = r.pc; redir_meta = r.meta;
    redir_taken = r.t; redir_ntaken = r.nt; redir_nonbr = r.nb;
    ab_v = av; ab_pc = a.pc; ab_meta = a.meta; ab_taken = a.t; ab_ntaken = a.nt;
    flush = fl;
    upd_yumi = yr & m_v & upd_v;
    #1;
    ready    = mq.size() < ELS;
    load_ok  = !m_v || upd_yumi;
    ab_av    = mq.size() > 0 && !fl;
    force_ab = (m_starve == LIM) && ab_av;
    gr       = load_ok && rv && !force_ab;
    ga       = load_ok && ab_av && (force_ab || !rv);
    chk("redir_yumi", 64'(redir_yumi), 64'(gr));
    chk("ab_ready",   64'(ab_ready),   64'(ready));
    chk("occupancy",  64'(occupancy),  64'(mq.size()));
    chk("upd_v",      64'(upd_v),      64'(m_v));
    enq = av && ready && !fl;
    if (fl) begin
      mq.delete();
      m_starve = 0;
    end else begin
      if (mq.size() == 0 || ga)    m_starve = 0;
      else if (gr && m_starve < LIM) m_starve++;
      if (ga)  sb.push_back(mq.pop_front());
      if (enq) mq.push_back(a);
    end
    if (gr) sb.push_back(r);
    if (load_ok) m_v = gr || ga;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3;
    idle_inputs();
    reset_n = 0;
    #1;
    chk("rst_upd_v",     64'(upd_v),     64'(0));
    chk("rst_occupancy", 64'(occupancy), 64'(0));
    chk("rst_ab_ready",  64'(ab_ready),  64'(1));
    chk("rst_upd_pc",    64'(upd_pc),    64'(0));
    chk("rst_upd_src",   64'(upd_src),   64'(0));
    chk("rst_redir_yumi", 64'(redir_yumi), 64'(0));
    mq.delete(); sb.delete(); m_v = 0; m_starve = 0;
    @(negedge clk);
    reset_n = 1;
  endtask

  // Monitor: every accepted update must match the oldest outstanding expectation.
  initial begin
    upd_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n && upd_v && upd_yumi) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL sb_empty: update pc %0h accepted with none expected", upd_pc);
        end else begin
          e = sb.pop_front();
          chk("upd_pc",   64'(upd_pc), 64'(e.pc));
          chk("upd_meta", upd_meta,    e.meta);
          chk("upd_flags", 64'({upd_taken, upd_ntaken, upd_nonbr, upd_src}),
                           64'({e.t, e.nt, e.nb, e.src}));
        end
      end
    end
  end

  initial begin
    tests = 0; fails = 0; m_v = 0; m_starve = 0;
    idle_inputs();
    reset_n = 0;
    do_reset();

    // Backpressure: redirect held 5 cycles while attaboys queue behind it.
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, i < 3, 0, 0);
      if (i == 0) hold_pc = upd_pc;
    end
    chk("hold_pc", 64'(upd_pc), 64'(hold_pc));

    // Redirect priority, then buffered attaboys drain in order.
    repeat (3) cycle(1, 0, 0, 1);
    repeat (4) cycle(0, 0, 0, 1);

    // Starvation: one buffered attaboy against continuous redirects.
    cycle(0, 1, 0, 1);
    repeat (12) cycle(1, 0, 0, 1);
    repeat (3) cycle(0, 0, 0, 1);

    // Full FIFO, single-cycle release, then traffic across pointer wrap.
    cycle(1, 0, 0, 0);
    repeat (5) cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 14; i++) cycle(0, 1, 0, 1);
    repeat (5) cycle(0, 0, 0, 1);

    // Flush with buffered attaboys and a held update; ab_v in the flush cycle is dropped.
    cycle(0, 1, 0, 0);
    repeat (3) cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 0);
    cycle(0, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 1);

    // Reset mid-stream with buffered attaboys and a valid update.
    cycle(1, 0, 0, 0);
    repeat (3) cycle(0, 1, 0, 0);
    do_reset();
    repeat (3) cycle(0, 0, 0, 1);

    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 55,
            $urandom_range(0, 99) < 3,  $urandom_range(0, 99) < 65);
      if (i == 700) do_reset();
    end

    repeat (10) cycle(0, 0, 0, 1);
    @(negedge clk);
    #3;
    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
